// File: rtl/bcd_tick_counter.sv
// Synchronizes a slow tick wave, detects its rising edges and counts them in BCD.
// Define BCD_SATURATE_EN to hold the count at all-9s instead of wrapping to zero.
module bcd_tick_counter #(
  parameter int DIGITS      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                cin,
  input  logic                rst_n,
  input  logic                tick_in,
  input  logic                start_stop,
  input  logic                clr,
  output logic [4*DIGITS-1:0] bcd,
  output logic                running,
  output logic                tick_seen,
  output logic                wrap
);

  typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} state_e;

  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'd9}};
  localparam logic [4*DIGITS-1:0] ALL_ZERO  = {4*DIGITS{1'b0}};

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic [4*DIGITS-1:0]    bcd_q, bcd_d;
  logic                   seen_q;
  logic                   wrap_q, wrap_d;
  logic                   rise_s;
  logic                   all9_s;

  // Ripple BCD increment: a digit rolls 9->0 and passes the carry upward.
  function automatic logic [4*DIGITS-1:0] bcd_inc(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic                c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  assign rise_s = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign all9_s = (bcd_q == ALL_NINES);

  // Next count and wrap flag; clear overrides any counted rise.
  always_comb begin
    bcd_d  = bcd_q;
    wrap_d = 1'b0;
    if (clr) begin
      bcd_d = ALL_ZERO;
    end else if (rise_s && (state_q == ST_RUN)) begin
`ifdef BCD_SATURATE_EN
      if (all9_s) begin
        bcd_d = bcd_q;
      end else begin
        bcd_d = bcd_inc(bcd_q);
      end
`else
      bcd_d  = bcd_inc(bcd_q);
      wrap_d = all9_s;
`endif
    end else begin
      bcd_d = bcd_q;
    end
  end

  // Synchronizer, edge history, run/stop FSM and registered outputs.
  always_ff @(posedge cin or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{1'b0}};
      hist_q  <= 1'b0;
      state_q <= ST_STOP;
      bcd_q   <= ALL_ZERO;
      seen_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      hist_q <= sync_q[SYNC_STAGES-1];
      seen_q <= rise_s;
      wrap_q <= wrap_d;
      bcd_q  <= bcd_d;
      case (state_q)
        ST_STOP: state_q <= start_stop ? ST_RUN : ST_STOP;
        ST_RUN:  state_q <= start_stop ? ST_STOP : ST_RUN;
        default: state_q <= ST_STOP;
      endcase
    end
  end

  assign bcd       = bcd_q;
  assign running   = (state_q == ST_RUN);
  assign tick_seen = seen_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Randomized self-checking bench for bcd_tick_counter against an integer count model.
module tb_bcd_tick_counter;
  localparam int DIGITS = 4;
  localparam int MOD    = 10000;
`ifdef BCD_SATURATE_EN
  localparam logic [15:0] WRAP_EXP  = 16'h9999;
  localparam int          WRAP_PULS = 0;
`else
  localparam logic [15:0] WRAP_EXP  = 16'h0000;
  localparam int          WRAP_PULS = 1;
`endif

  logic        cin = 1'b0;
  logic        rst_n = 1'b1;
  logic        tick_in = 1'b0;
  logic        start_stop = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] bcd;
  logic        running, tick_seen, wrap;

  int checks = 0, errors = 0;
  int m_count = 0, m_seen = 0, m_wraps = 0;
  bit m_running = 1'b0;
  int seen_cnt = 0, wrap_cnt = 0, consec_cnt = 0;
  logic prev_seen = 1'b0, prev_wrap = 1'b0;

  bcd_tick_counter #(.DIGITS(DIGITS), .SYNC_STAGES(2)) dut (
    .cin(cin), .rst_n(rst_n), .tick_in(tick_in), .start_stop(start_stop), .clr(clr),
    .bcd(bcd), .running(running), .tick_seen(tick_seen), .wrap(wrap)
  );

  always #5 cin = ~cin;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Pulse counters and back-to-back detection, sampled on the falling edge.
  always @(negedge cin) begin
    if (tick_seen === 1'b1) seen_cnt++;
    if (wrap === 1'b1) wrap_cnt++;
    if ((tick_seen === 1'b1 && prev_seen === 1'b1) || (wrap === 1'b1 && prev_wrap === 1'b1)) consec_cnt++;
    prev_seen = tick_seen;
    prev_wrap = wrap;
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_rise;
    m_seen++;
    if (m_running) begin
      if (m_count == MOD - 1) begin
`ifdef BCD_SATURATE_EN
        m_count = MOD - 1;
`else
        m_count = 0;
        m_wraps++;
`endif
      end else begin
        m_count++;
      end
    end
  endtask

  task automatic rise(input int hi, input int lo);
    @(negedge cin); tick_in = 1'b1;
    repeat (hi) @(negedge cin);
    tick_in = 1'b0;
    repeat (lo) @(negedge cin);
    model_rise();
  endtask

  task automatic start_pulse;
    @(negedge cin); start_stop = 1'b1;
    @(negedge cin); start_stop = 1'b0;
    m_running = ~m_running;
  endtask

  task automatic clr_pulse;
    @(negedge cin); clr = 1'b1;
    @(negedge cin); clr = 1'b0;
    m_count = 0;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge cin); tick_in = 1'($urandom_range(0, 1));
      checks++;
      if (bcd !== 16'h0000 || running !== 1'b0 || tick_seen !== 1'b0 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL reset: bcd=%h running=%b seen=%b wrap=%b required 0000/0/0/0", bcd, running, tick_seen, wrap);
      end
    end
    @(negedge cin); tick_in = 1'b0;
    repeat (3) @(negedge cin);
    rst_n = 1'b1;
    @(negedge cin);
  endtask

  task automatic test_count_stop;
    int base;
    logic exp;
    start_pulse();
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL start: running=%b required 1", running); end
    for (int r = 0; r < 12; r++) begin
      @(negedge cin); tick_in = 1'b1;
      for (int c = 1; c <= 4; c++) begin
        @(negedge cin);
        exp = (c == 3);
        checks++;
        if (tick_seen !== exp) begin
          errors++;
          $display("FAIL tick_latency: rise %0d cycle %0d tick_seen=%b required %b", r, c, tick_seen, exp);
        end
        if (c == 3) begin
          model_rise();
          checks++;
          if (bcd !== to_bcd(m_count)) begin
            errors++;
            $display("FAIL count_update: bcd=%h required %h", bcd, to_bcd(m_count));
          end
        end
      end
      repeat (6) @(negedge cin);
      tick_in = 1'b0;
      repeat (10) @(negedge cin);
    end
    checks++;
    if (bcd !== 16'h0012) begin errors++; $display("FAIL count12: bcd=%h required 0012", bcd); end
    start_pulse();
    base = seen_cnt;
    for (int r = 0; r < 3; r++) rise(10, 10);
    checks++;
    if (bcd !== 16'h0012 || running !== 1'b0 || seen_cnt - base != 3) begin
      errors++;
      $display("FAIL stopped: bcd=%h running=%b seen=%0d required 0012/0/3", bcd, running, seen_cnt - base);
    end
  endtask

  task automatic test_carry;
    start_pulse();
    clr_pulse();
    repeat (9) rise(2, 2);
    checks++;
    if (bcd !== 16'h0009) begin errors++; $display("FAIL carry_pre9: bcd=%h required 0009", bcd); end
    rise(2, 2);
    checks++;
    if (bcd !== 16'h0010) begin errors++; $display("FAIL carry_9_10: bcd=%h required 0010", bcd); end
    while (m_count < 199) rise(2, 2);
    checks++;
    if (bcd !== 16'h0199) begin errors++; $display("FAIL carry_pre199: bcd=%h required 0199", bcd); end
    rise(2, 2);
    checks++;
    if (bcd !== 16'h0200) begin errors++; $display("FAIL carry_199_200: bcd=%h required 0200", bcd); end
  endtask

  task automatic test_wrap;
    int base;
    base = wrap_cnt;
    while (m_count < MOD - 1) rise(2, 2);
    checks++;
    if (bcd !== 16'h9999 || wrap_cnt != base) begin
      errors++;
      $display("FAIL pre_wrap: bcd=%h wraps=%0d required 9999/0", bcd, wrap_cnt - base);
    end
    base = wrap_cnt;
    rise(2, 2);
    checks++;
    if (bcd !== WRAP_EXP || wrap_cnt - base != WRAP_PULS) begin
      errors++;
      $display("FAIL wrap: bcd=%h wraps=%0d required %h/%0d", bcd, wrap_cnt - base, WRAP_EXP, WRAP_PULS);
    end
    rise(2, 2);
    checks++;
    if (bcd !== to_bcd(m_count)) begin errors++; $display("FAIL post_wrap: bcd=%h required %h", bcd, to_bcd(m_count)); end
  endtask

  task automatic test_clr;
    clr_pulse();
    repeat (42) rise(2, 2);
    checks++;
    if (bcd !== 16'h0042) begin errors++; $display("FAIL clr_pre42: bcd=%h required 0042", bcd); end
    @(negedge cin); tick_in = 1'b1;
    @(negedge cin);
    @(negedge cin); clr = 1'b1;
    @(negedge cin); clr = 1'b0;
    m_seen++;
    m_count = 0;
    checks++;
    if (bcd !== 16'h0000 || tick_seen !== 1'b1 || wrap !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL clr_vs_rise: bcd=%h seen=%b wrap=%b running=%b required 0000/1/0/1", bcd, tick_seen, wrap, running);
    end
    repeat (3) @(negedge cin); tick_in = 1'b0;
    repeat (3) @(negedge cin);
    start_pulse();
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL stop: running=%b required 0", running); end
    @(negedge cin); tick_in = 1'b1;
    @(negedge cin);
    @(negedge cin); start_stop = 1'b1;
    @(negedge cin); start_stop = 1'b0;
    m_seen++;
    m_running = 1'b1;
    checks++;
    if (running !== 1'b1 || tick_seen !== 1'b1 || bcd !== 16'h0000) begin
      errors++;
      $display("FAIL start_with_rise: running=%b seen=%b bcd=%h required 1/1/0000", running, tick_seen, bcd);
    end
    repeat (3) @(negedge cin); tick_in = 1'b0;
    repeat (3) @(negedge cin);
    checks++;
    if (bcd !== 16'h0000) begin errors++; $display("FAIL start_rise_uncounted: bcd=%h required 0000", bcd); end
  endtask

  task automatic test_async_reset;
    int base;
    clr_pulse();
    while (m_count < 357) rise(2, 2);
    checks++;
    if (bcd !== 16'h0357 || running !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: bcd=%h running=%b required 0357/1", bcd, running);
    end
    @(posedge cin); #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bcd !== 16'h0000 || running !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: bcd=%h running=%b required 0000/0", bcd, running);
    end
    tick_in = 1'b1;
    repeat (3) @(negedge cin);
    rst_n = 1'b1;
    m_count = 0;
    m_running = 1'b0;
    m_seen++;
    base = seen_cnt;
    repeat (10) @(negedge cin);
    checks++;
    if (seen_cnt - base != 1 || bcd !== 16'h0000 || running !== 1'b0) begin
      errors++;
      $display("FAIL release_high: seen=%0d bcd=%h running=%b required 1/0000/0", seen_cnt - base, bcd, running);
    end
    tick_in = 1'b0;
    repeat (3) @(negedge cin);
  endtask

  task automatic test_random;
    int op;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 9);
      if (op == 0) start_pulse();
      else if (op == 1) clr_pulse();
      else rise($urandom_range(2, 6), $urandom_range(2, 6));
      checks++;
      if (bcd !== to_bcd(m_count) || running !== m_running) begin
        errors++;
        $display("FAIL random[%0d] op=%0d: bcd=%h running=%b required %h/%b", i, op, bcd, running, to_bcd(m_count), m_running);
      end
    end
  endtask

  task automatic test_pulses;
    repeat (3) @(negedge cin);
    checks++;
    if (consec_cnt != 0 || seen_cnt != m_seen || wrap_cnt != m_wraps) begin
      errors++;
      $display("FAIL pulse_totals: consec=%0d seen=%0d wraps=%0d required 0/%0d/%0d", consec_cnt, seen_cnt, wrap_cnt, m_seen, m_wraps);
    end
  endtask

  initial begin
    test_reset();
    test_count_stop();
    test_carry();
    test_wrap();
    test_clr();
    test_async_reset();
    test_random();
    test_pulses();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
